// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive FIFO behind the UART receiver with sticky overrun.
// Optional almost_full output is built when UART_RX_FIFO_AF_EN is defined.
module uart_rx_fifo #(
  parameter int DBITS    = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done_tick,
  input  logic [DBITS-1:0]  rx_dout,
  input  logic              rd_en,
  input  logic              clr_overrun,
  output logic [DBITS-1:0]  r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
`ifdef UART_RX_FIFO_AF_EN
  ,
  output logic              almost_full
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DBITS-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              rd_ok;
  logic              wr_ok;
  logic              overflow;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a byte alongside a pop.
  always_comb begin
    rd_ok    = rd_en && !empty;
    wr_ok    = rx_done_tick && (!full || rd_ok);
    overflow = rx_done_tick && full && !rd_ok;
    count_next = count;
    if (wr_ok && !rd_ok) begin
      count_next = count + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= rx_dout;
    end
  end

  assign r_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH_CNT);
      // Set has priority over clear so an overflow coinciding with a clear is never lost.
      if (overflow) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_AF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_next >= (ADDR_W + 1)'(AF_LEVEL));
    end
  end
`else
  logic unused_af_level;
  assign unused_af_level = ^AF_LEVEL;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with directed vectors.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = '0;
  logic       rd_en = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
`ifdef UART_RX_FIFO_AF_EN
  logic       almost_full;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rd_en        (rd_en),
    .clr_overrun  (clr_overrun),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overrun      (overrun)
`ifdef UART_RX_FIFO_AF_EN
    ,
    .almost_full  (almost_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", r_data);
      end else begin
        chk("pop_data", int'(r_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input logic t, input logic [7:0] d, input logic r, input logic c);
    rx_done_tick = t;
    rx_dout      = d;
    rd_en        = r;
    clr_overrun  = c;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    rd_en        = 1'b0;
    clr_overrun  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    exp_q.push_back(d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_overrun", int'(overrun), 0);

    wr(8'hA5);
    chk("single_empty", int'(empty), 0);
    chk("single_count", int'(count), 1);
    chk("single_rdata", int'(r_data), 8'hA5);
    pop();
    chk("single_pop_empty", int'(empty), 1);
    chk("single_pop_count", int'(count), 0);

    pop();
    chk("pop_when_empty_count", int'(count), 0);
    chk("pop_when_empty_ovr", int'(overrun), 0);

    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);
    chk("fill_overrun", int'(overrun), 0);

    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_overrun", int'(overrun), 1);
    chk("ovf_count", int'(count), 16);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_overrun", int'(overrun), 0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b1);
    chk("clr_plus_ovf", int'(overrun), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_again", int'(overrun), 0);

    exp_q.push_back(8'h55);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_simul_count", int'(count), 16);
    chk("full_simul_overrun", int'(overrun), 0);
    chk("full_simul_full", int'(full), 1);

    for (int i = 0; i < 16; i++) pop();
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);
    chk("drain_overrun", int'(overrun), 0);

    exp_q.push_back(8'h33);
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    chk("empty_simul_count", int'(count), 1);
    chk("empty_simul_rdata", int'(r_data), 8'h33);
    pop();

    for (int i = 0; i < 40; i++) begin
      wr(8'(i * 7 + 3));
      if (i % 3 == 2) begin
        chk("wrap_count", int'(count), 3);
        repeat (3) pop();
      end
    end
    pop();
    chk("wrap_empty", int'(empty), 1);

    for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
    chk("pre_reset_count", int'(count), 5);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    exp_q.push_back(8'hEE);
    do_reset();
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_overrun", int'(overrun), 0);
    wr(8'h77);
    chk("post_rst_rdata", int'(r_data), 8'h77);
    chk("post_rst_count", int'(count), 1);
    pop();

`ifdef UART_RX_FIFO_AF_EN
    for (int i = 0; i < 11; i++) wr(8'h10 + 8'(i));
    chk("af_at_11", int'(almost_full), 0);
    wr(8'h1B);
    chk("af_at_12", int'(almost_full), 1);
    pop();
    chk("af_after_pop", int'(almost_full), 0);
    repeat (11) pop();
`endif

    chk("final_empty", int'(empty), 1);
    chk("final_queue_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
